// File: rtl/mips_dmem_responder.sv
// Word-organised data memory sitting on the CPU's data bus; answers load/store
// requests after a fixed wait latency and flags misaligned or out-of-range accesses.
module mips_dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

    state_t state;
    state_t state_next;

    logic [3:0]        counter;
    logic              write_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              err_q;
    logic              req_err;
    logic              commit;

    logic [31:0] mem [2**ADDR_W];

    // Any address bit above the word index, or a non-zero byte offset, is an error.
    assign req_err = (req_addr[1:0] != 2'b00) | ((req_addr >> (ADDR_W + 2)) != 32'd0);
    assign commit  = (state == WAIT) && (counter == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = ~reset;
                if (req_valid) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (counter == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture, latency countdown and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter    <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        idx_q   <= req_addr[ADDR_W+1:2];
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        err_q   <= req_err;
                        counter <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        resp_err   <= err_q;
                        resp_rdata <= (!write_q && !err_q) ? mem[idx_q] : 32'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && write_q && !err_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed self-checking bench for mips_dmem_responder (ADDR_W=10, LATENCY=2).
module tb_mips_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    mips_dmem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_be(req_be),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one full transaction; lat counts edges from acceptance to resp_valid.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] be, output logic [31:0] rd,
                                 output logic er, output int lat);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        for (int i = 0; i < 20 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (req_ready !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_ready_low: got %b expected 0", req_ready);
            end
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++; $display("[TB] FAIL reset_valid_low: got %b expected 0", resp_valid);
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL release_ready: got %b expected 1", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL release_valid: got %b expected 0", resp_valid);
        end
        checks++;
        if (resp_rdata !== 32'd0) begin
            errors++; $display("[TB] FAIL release_rdata: got %h expected 00000000", resp_rdata);
        end
        checks++;
        if (resp_err !== 1'b0) begin
            errors++; $display("[TB] FAIL release_err: got %b expected 0", resp_err);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd;
        logic er;
        int lat;
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        checks++;
        if (lat !== 2) begin
            errors++; $display("[TB] FAIL store_latency: got %0d expected 2", lat);
        end
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            errors++; $display("[TB] FAIL store_resp: got %h/%b expected 00000000/0", rd, er);
        end
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (lat !== 2) begin
            errors++; $display("[TB] FAIL load_latency: got %0d expected 2", lat);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++; $display("[TB] FAIL load_full: got %h/%b expected deadbeef/0", rd, er);
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd;
        logic er;
        int lat;
        applyStimulus(1'b1, 32'h10, 32'h00001234, 4'h3, rd, er, lat);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD1234 || er !== 1'b0) begin
            errors++; $display("[TB] FAIL partial_store: got %h/%b expected dead1234/0", rd, er);
        end
        applyStimulus(1'b1, 32'h10, 32'hCAFEF00D, 4'h0, rd, er, lat);
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD1234) begin
            errors++; $display("[TB] FAIL be_zero_store: got %h expected dead1234", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic er;
        int lat;
        applyStimulus(1'b0, 32'h12, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            errors++; $display("[TB] FAIL misaligned_load: got %h/%b expected 00000000/1", rd, er);
        end
        applyStimulus(1'b0, 32'h00001000, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            errors++; $display("[TB] FAIL range_load: got %h/%b expected 00000000/1", rd, er);
        end
        applyStimulus(1'b1, 32'h14, 32'h55667788, 4'hF, rd, er, lat);
        applyStimulus(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin
            errors++; $display("[TB] FAIL misaligned_store_err: got %b expected 1", er);
        end
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD1234) begin
            errors++; $display("[TB] FAIL misaligned_store_w10: got %h expected dead1234", rd);
        end
        applyStimulus(1'b0, 32'h14, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h55667788) begin
            errors++; $display("[TB] FAIL misaligned_store_w14: got %h expected 55667788", rd);
        end
        applyStimulus(1'b1, 32'hFFC, 32'hA5A5A5A5, 4'hF, rd, er, lat);
        applyStimulus(1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hA5A5A5A5 || er !== 1'b0) begin
            errors++; $display("[TB] FAIL top_word: got %h/%b expected a5a5a5a5/0", rd, er);
        end
    endtask

    task automatic test_stall();
        int n;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        req_be    = 4'h0;
        @(posedge clk); #1;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 2) begin
            errors++; $display("[TB] FAIL stall_latency: got %0d expected 2", n);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD1234 || req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_hold: got v=%b d=%h r=%b expected v=1 d=dead1234 r=0",
                         resp_valid, resp_rdata, req_ready);
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL stall_release: got v=%b r=%b expected v=0 r=1", resp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL next_accept: got ready=%b expected 0", req_ready);
        end
        n = 0;
        while (!resp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD1234) begin
            errors++; $display("[TB] FAIL next_resp: got v=%b d=%h expected v=1 d=dead1234", resp_valid, resp_rdata);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h10;
        resp_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            checks++;
            if (req_ready !== (i % 4 == 0) || resp_valid !== (i % 4 == 3)) begin
                errors++;
                $display("[TB] FAIL b2b_cycle%0d: got r=%b v=%b expected r=%b v=%b",
                         i, req_ready, resp_valid, (i % 4 == 0), (i % 4 == 3));
            end
            if (i % 4 == 3) begin
                checks++;
                if (resp_rdata !== 32'hDEAD1234) begin
                    errors++; $display("[TB] FAIL b2b_data%0d: got %h expected dead1234", i, resp_rdata);
                end
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic er;
        int lat;
        applyStimulus(1'b1, 32'h20, 32'h11111111, 4'hF, rd, er, lat);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h22222222;
        req_be    = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL wait_reset: got v=%b r=%b expected v=0 r=0", resp_valid, req_ready);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL post_reset_idle: got v=%b r=%b expected v=0 r=1", resp_valid, req_ready);
            end
        end
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h11111111 || er !== 1'b0) begin
            errors++; $display("[TB] FAIL aborted_store: got %h/%b expected 11111111/0", rd, er);
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h20;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL resp_before_reset: got %b expected 1", resp_valid);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
            errors++; $display("[TB] FAIL resp_reset_drop: got v=%b d=%h expected v=0 d=00000000", resp_valid, resp_rdata);
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_be     = 4'd0;
        resp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_partial_store();
        test_errors();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_dmem_responder.md
# mips_dmem_responder

Word-organised data-memory responder that services load/store requests issued by the MIPS CPU core over a valid/ready request channel and returns results over a valid/ready response channel. Accesses complete after a fixed, parameterised wait latency. Misaligned and out-of-range accesses return an error flag. The block sits beside the CPU in the top-level system, as the memory-side end of the CPU's data bus.

## Interface
- ADDR_W, 10, word-address bits; memory depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, wait cycles between request acceptance and response; legal range 1..15.

- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU presents a request.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  store byte enables; bit i enables bits [8i+7:8i].
- resp_valid  output  1  response available.
- resp_ready  input  1  CPU accepts the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - When req_valid & req_ready at an edge: capture write, addr, wdata, be; compute err; load counter with LATENCY-1; go to WAIT.
- Error rule: err = (addr[1:0] != 0) | (addr[31:ADDR_W+2] != 0).
- WAIT:
  - req_ready = 0.
  - At each edge with counter != 0, decrement.
  - At the edge with counter == 0, go to RESP and commit the access at that same edge:
    - Load, no err: resp_rdata <= mem[addr[ADDR_W+1:2]] (full word; be ignored).
    - Store, no err: write only the enabled bytes; resp_rdata <= 0. be = 0 is a legal no-op store.
    - err: no memory access; resp_rdata <= 0.
    - resp_err <= err in all cases.
- RESP:
  - resp_valid = 1; req_ready = 0.
  - resp_rdata and resp_err hold stable until the handshake.
  - At the edge with resp_valid & resp_ready, go to IDLE; resp_valid drops.
- One outstanding transaction only. req_valid while not ready is ignored, and the CPU must hold its request until accepted.
- Memory contents are not initialised by reset.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, counter 0.
- req_ready is 0 whenever reset is high; it is combinational: (state == IDLE) & ~reset.
- Latency: request accepted at edge E0 gives resp_valid high immediately after edge E0+LATENCY.
- Back-to-back throughput:
  - resp_ready held high: accepted at E0, response taken at E0+LATENCY+1, IDLE at that point, next request accepted at E0+LATENCY+2.
  - Maximum rate is one transaction per LATENCY+2 cycles.
- Response stall: any number of cycles with resp_ready = 0 keeps the block in RESP with outputs unchanged.
- Reset mid-operation:
  - Reset in WAIT aborts the transaction. A store whose commit edge coincides with reset is not written.
  - Reset in RESP drops the response.
  - A store already committed before reset remains in memory.
- Simultaneous events: req_valid in RESP, even during the response handshake edge, is not accepted until the next IDLE cycle.

## Test plan
- Reset is held for 3 cycles, then released → req_ready goes 0 → 1 and resp_valid stays 0.
- Store addr 0x10, wdata 0xDEADBEEF, be 0xF, then load 0x10 → load response has rdata 0xDEADBEEF and err 0. resp_valid rises exactly LATENCY edges after acceptance.
- Partial store addr 0x10, wdata 0x00001234, be 0x3, then load 0x10 → rdata 0xDEAD1234.
- Load addr 0x12 (misaligned) → err 1, rdata 0. Load addr 0x00001000 with ADDR_W=10 (out of range) → err 1, rdata 0. A store to 0x12 leaves words 0x10 and 0x14 unchanged.
- resp_ready is held 0 for 5 cycles with req_valid kept high → resp_valid and data stay stable and no second request is accepted. After the handshake, the next request is accepted one cycle later.
- Reset is asserted during WAIT of a store to 0x20 holding old value 0x11111111 → after reset, a load of 0x20 returns 0x11111111 and no stale resp_valid appears.
